// File: rtl/mem_access_sequencer_pkg.sv
// Shared control-unit definitions for the load/store memory access sequencer:
// state encoding, supported instruction classes, IR field positions and the output bundle.
package mem_access_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_DATA     = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_BASE_WB  = 3'd4,
        ST_LOAD_WB  = 3'd5,
        ST_DONE     = 3'd6,
        ST_ABORT    = 3'd7
    } state_t;

    localparam logic [2:0] CLASS_IMM = 3'b010;
    localparam logic [2:0] CLASS_REG = 3'b011;

    localparam int IR_L        = 20;
    localparam int IR_W        = 21;
    localparam int IR_B        = 22;
    localparam int IR_U        = 23;
    localparam int IR_P        = 24;
    localparam int IR_CLASS_LO = 25;
    localparam int IR_RN_LO    = 16;
    localparam int IR_RD_LO    = 12;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       abort;
        logic       illegal;
        logic       mar_ld;
        logic       mdr_ld;
        logic       mem_req;
        logic       mem_rw;
        logic       mem_byte;
        logic       rf_ld;
        logic [3:0] rf_dst;
        logic       rf_src_mdr;
        logic       alu_sub;
        logic       alu_b_reg;
        logic       addr_base;
    } ctrl_t;

    function automatic logic is_supported(input logic [31:0] ir);
        logic [2:0] cls;
        cls = ir[IR_CLASS_LO +: 3];
        return (cls == CLASS_IMM) || (cls == CLASS_REG);
    endfunction

endpackage

// File: rtl/mem_access_sequencer_timeout.sv
// MEM_WAIT timeout counter: counts wait cycles without completion; expired flags the
// cycle whose end would reach the limit.
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // The increment at the end of this cycle would make the count equal the limit.
    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_sequencer.sv
// Load/store memory access sequencer: walks an accepted instruction through address,
// data, memory wait and writeback phases with registered control outputs.
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] instruction,
    input  logic        moc,
    output logic        busy,
    output logic        done,
    output logic        abort,
    output logic        illegal,
    output logic        mar_ld,
    output logic        mdr_ld,
    output logic        mem_req,
    output logic        mem_rw,
    output logic        mem_byte,
    output logic        rf_ld,
    output logic [3:0]  rf_dst,
    output logic        rf_src_mdr,
    output logic        alu_sub,
    output logic        alu_b_reg,
    output logic        addr_base
);

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic        illegal_d;
    ctrl_t       out_q, out_d;
    logic        expired;

    mem_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_q != ST_MEM_WAIT),
        .enable  ((state_q == ST_MEM_WAIT) && !moc),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ir_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (is_supported(instruction)) begin
                        ir_d    = instruction;
                        state_d = ST_ADDR;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_ADDR:     state_d = ir_q[IR_L] ? ST_MEM_WAIT : ST_DATA;
            ST_DATA:     state_d = ST_MEM_WAIT;
            ST_MEM_WAIT: begin
                // Completion takes priority over a timeout in the same cycle.
                if (moc) begin
                    if (!ir_q[IR_P] || ir_q[IR_W]) state_d = ST_BASE_WB;
                    else if (ir_q[IR_L])            state_d = ST_LOAD_WB;
                    else                            state_d = ST_DONE;
                end else if (expired) begin
                    state_d = ST_ABORT;
                end
            end
            ST_BASE_WB:  state_d = ir_q[IR_L] ? ST_LOAD_WB : ST_DONE;
            ST_LOAD_WB:  state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            ST_ABORT:    state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and IR so they register in step with the state.
    always_comb begin
        out_d         = '0;
        out_d.busy    = (state_d != ST_IDLE);
        out_d.illegal = illegal_d;
        case (state_d)
            ST_ADDR: begin
                out_d.mar_ld    = 1'b1;
                out_d.addr_base = ~ir_d[IR_P];
                out_d.alu_sub   = ~ir_d[IR_U];
                out_d.alu_b_reg = ir_d[IR_CLASS_LO];
            end
            ST_DATA:     out_d.mdr_ld = 1'b1;
            ST_MEM_WAIT: begin
                out_d.mem_req  = 1'b1;
                out_d.mem_rw   = ir_d[IR_L];
                out_d.mem_byte = ir_d[IR_B];
            end
            ST_BASE_WB: begin
                out_d.rf_ld     = 1'b1;
                out_d.rf_dst    = ir_d[IR_RN_LO +: 4];
                out_d.alu_sub   = ~ir_d[IR_U];
                out_d.alu_b_reg = ir_d[IR_CLASS_LO];
            end
            ST_LOAD_WB: begin
                out_d.rf_ld      = 1'b1;
                out_d.rf_dst     = ir_d[IR_RD_LO +: 4];
                out_d.rf_src_mdr = 1'b1;
            end
            ST_DONE:  out_d.done  = 1'b1;
            ST_ABORT: out_d.abort = 1'b1;
            default: ;
        endcase
    end

    assign busy       = out_q.busy;
    assign done       = out_q.done;
    assign abort      = out_q.abort;
    assign illegal    = out_q.illegal;
    assign mar_ld     = out_q.mar_ld;
    assign mdr_ld     = out_q.mdr_ld;
    assign mem_req    = out_q.mem_req;
    assign mem_rw     = out_q.mem_rw;
    assign mem_byte   = out_q.mem_byte;
    assign rf_ld      = out_q.rf_ld;
    assign rf_dst     = out_q.rf_dst;
    assign rf_src_mdr = out_q.rf_src_mdr;
    assign alu_sub    = out_q.alu_sub;
    assign alu_b_reg  = out_q.alu_b_reg;
    assign addr_base  = out_q.addr_base;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: a reference model lists the expected
// per-cycle control outputs of each transaction and the DUT is compared cycle by cycle.
module tb_mem_access_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] instruction = '0;
    logic        moc = 1'b0;
    logic        busy, done, abort, illegal, mar_ld, mdr_ld, mem_req, mem_rw, mem_byte;
    logic        rf_ld, rf_src_mdr, alu_sub, alu_b_reg, addr_base;
    logic [3:0]  rf_dst;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [17:0] vec;
        bit          moc_next;
        bit          in_wait;
    } step_t;

    step_t exp_q[$];

    mem_access_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .instruction(instruction), .moc(moc),
        .busy(busy), .done(done), .abort(abort), .illegal(illegal), .mar_ld(mar_ld),
        .mdr_ld(mdr_ld), .mem_req(mem_req), .mem_rw(mem_rw), .mem_byte(mem_byte),
        .rf_ld(rf_ld), .rf_dst(rf_dst), .rf_src_mdr(rf_src_mdr), .alu_sub(alu_sub),
        .alu_b_reg(alu_b_reg), .addr_base(addr_base)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] pk(input logic bsy, dn, ab, il, mar, mdr, req, rw, byt, rfl,
                                       input logic [3:0] dst, input logic src, sub, breg, base);
        return {bsy, dn, ab, il, mar, mdr, req, rw, byt, rfl, dst, src, sub, breg, base};
    endfunction

    function automatic logic [17:0] observed();
        return pk(busy, done, abort, illegal, mar_ld, mdr_ld, mem_req, mem_rw, mem_byte, rf_ld,
                  rf_dst, rf_src_mdr, alu_sub, alu_b_reg, addr_base);
    endfunction

    function automatic logic [31:0] mk(input logic [2:0] cls, input logic p, u, b, w, l,
                                       input logic [3:0] rn, rd);
        logic [31:0] ins;
        ins = $urandom;
        ins[27:25] = cls; ins[24] = p; ins[23] = u; ins[22] = b; ins[21] = w; ins[20] = l;
        ins[19:16] = rn;  ins[15:12] = rd;
        return ins;
    endfunction

    function automatic void push(input logic [17:0] v, input bit m, input bit w);
        step_t s;
        s.vec = v; s.moc_next = m; s.in_wait = w;
        exp_q.push_back(s);
    endfunction

    // waitc: number of memory-wait cycles that pass without completion before moc arrives.
    function automatic void model(input logic [31:0] ins, input int waitc);
        logic [2:0] cls;
        logic p, u, b, w, l, sub, breg;
        logic [3:0] rn, rd;
        int nwait;
        cls = ins[27:25]; p = ins[24]; u = ins[23]; b = ins[22]; w = ins[21]; l = ins[20];
        rn = ins[19:16];  rd = ins[15:12];
        if (cls != 3'b010 && cls != 3'b011) begin
            push(pk(0,0,0,1,0,0,0,0,0,0,4'd0,0,0,0,0), 0, 0);
            push('0, 0, 0);
            return;
        end
        sub = ~u; breg = cls[0];
        push(pk(1,0,0,0,1,0,0,0,0,0,4'd0,0,sub,breg,~p), 0, 0);
        if (!l) push(pk(1,0,0,0,0,1,0,0,0,0,4'd0,0,0,0,0), 0, 0);
        nwait = (waitc + 1 > TO) ? TO : waitc + 1;
        for (int k = 1; k <= nwait; k++)
            push(pk(1,0,0,0,0,0,1,l,b,0,4'd0,0,0,0,0), (k == waitc + 1), 1);
        if (waitc >= TO) begin
            push(pk(1,0,1,0,0,0,0,0,0,0,4'd0,0,0,0,0), 0, 0);
        end else begin
            if (!p || w) push(pk(1,0,0,0,0,0,0,0,0,1,rn,0,sub,breg,0), 0, 0);
            if (l)       push(pk(1,0,0,0,0,0,0,0,0,1,rd,1,0,0,0), 0, 0);
            push(pk(1,1,0,0,0,0,0,0,0,0,4'd0,0,0,0,0), 0, 0);
        end
        push('0, 0, 0);
    endfunction

    task automatic run_txn(input logic [31:0] ins, input int waitc, input string name,
                           input bit poke_start);
        step_t s;
        logic [17:0] got;
        int idx;
        exp_q.delete();
        model(ins, waitc);
        @(negedge clk);
        start = 1'b1;
        instruction = ins;
        idx = 0;
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            @(negedge clk);
            got = observed();
            n_cmp++;
            if (got !== s.vec) begin
                n_bad++;
                $display("FAIL %s step %0d: got %h required %h (ins %h)", name, idx, got, s.vec, ins);
            end
            moc = s.moc_next;
            start = (poke_start && s.in_wait) ? 1'($urandom_range(0, 1)) : 1'b0;
            instruction = $urandom;
            idx++;
        end
        moc = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (observed() !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h required 0", observed());
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_store_imm();
        run_txn(mk(3'b010, 1, 1, 0, 0, 0, 4'd2, 4'd9), 0, "store_imm", 0);
    endtask

    task automatic test_load_byte_pre();
        run_txn(mk(3'b011, 1, 0, 1, 1, 1, 4'd3, 4'd5), 3, "load_byte_pre", 0);
    endtask

    task automatic test_load_post_same_reg();
        run_txn(mk(3'b010, 0, 1, 0, 0, 1, 4'd7, 4'd7), 1, "load_post_rd_eq_rn", 0);
    endtask

    task automatic test_timeout();
        run_txn(mk(3'b010, 1, 1, 0, 0, 0, 4'd1, 4'd4), TO, "timeout_abort", 0);
        run_txn(mk(3'b011, 1, 1, 0, 0, 1, 4'd1, 4'd4), TO - 1, "moc_on_last_cycle", 0);
    endtask

    task automatic test_illegal();
        run_txn(mk(3'b101, 1, 1, 0, 0, 1, 4'd1, 4'd2), 0, "illegal_class", 0);
        run_txn(mk(3'b010, 1, 1, 0, 0, 1, 4'd6, 4'd8), 5, "start_in_mem_wait", 1);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1;
        instruction = mk(3'b010, 1, 1, 0, 0, 0, 4'd2, 4'd3);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_pre: mem_req got %b required 1", mem_req);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (observed() !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_async: got %h required 0", observed());
        end
        @(negedge clk);
        reset_n = 1'b1;
        run_txn(mk(3'b011, 0, 0, 0, 0, 1, 4'd10, 4'd11), 2, "after_reset", 0);
    endtask

    task automatic test_random();
        logic [31:0] ins;
        int waitc;
        for (int i = 0; i < 16; i++) begin
            ins = $urandom;
            case ($urandom_range(0, 4))
                0, 1:    ins[27:25] = 3'b010;
                2, 3:    ins[27:25] = 3'b011;
                default: ins[27:25] = 3'($urandom_range(0, 7));
            endcase
            waitc = ($urandom_range(0, 3) == 0) ? $urandom_range(TO - 1, TO + 2)
                                                : $urandom_range(0, 6);
            run_txn(ins, waitc, "random", 1);
        end
    endtask

    initial begin
        test_reset();
        test_store_imm();
        test_load_byte_pre();
        test_load_post_same_reg();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
